// File: rtl/exp_stream.sv
// exp_stream: LANES-wide streaming fixed-point e^x, 3-stage valid/ready pipe.
// Ports: clk, arst_n; i_valid/i_ready/i_data/i_last in; o_valid/o_ready/o_data/o_last out; o_sat_cnt.
module exp_stream #(
  parameter int INT_BIT  = 5,
  parameter int FRAC_BIT = 11,
  parameter int DWIDTH   = 16,
  parameter int LANES    = 4,
  parameter int SEG_BITS = 3
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [LANES*DWIDTH-1:0] i_data,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [LANES*DWIDTH-1:0] o_data,
  output logic                    o_last,
  output logic [15:0]             o_sat_cnt
);

  localparam int RB     = FRAC_BIT - SEG_BITS;
  localparam int PW     = 2 * DWIDTH;
  localparam int CW     = $clog2(LANES + 1);
  localparam int HALF_R = 1 << (RB - 1);
  localparam int HALF_F = 1 << (FRAC_BIT - 1);
  localparam logic [DWIDTH-1:0] MAXV = {1'b0, {(DWIDTH-1){1'b1}}};

  // {clamped, round(e^n * 2^11)}; tables are built for 5.11 / 8 segments
  function automatic logic [DWIDTH:0] exp_int(input int n);
    logic [DWIDTH:0] e;
    e = '0;
    case (n)
      -8:      e = (DWIDTH+1)'(1);
      -7:      e = (DWIDTH+1)'(2);
      -6:      e = (DWIDTH+1)'(5);
      -5:      e = (DWIDTH+1)'(14);
      -4:      e = (DWIDTH+1)'(38);
      -3:      e = (DWIDTH+1)'(102);
      -2:      e = (DWIDTH+1)'(277);
      -1:      e = (DWIDTH+1)'(753);
      0:       e = (DWIDTH+1)'(2048);
      1:       e = (DWIDTH+1)'(5567);
      2:       e = (DWIDTH+1)'(15133);
      default: e = (n > 2) ? {1'b1, MAXV} : '0;
    endcase
    return e;
  endfunction

  // segment endpoints round(e^(k/8) * 2^11), k = 0..8
  function automatic logic [DWIDTH-1:0] seg_y(input int k);
    logic [DWIDTH-1:0] y;
    case (k)
      0:       y = DWIDTH'(2048);
      1:       y = DWIDTH'(2321);
      2:       y = DWIDTH'(2630);
      3:       y = DWIDTH'(2980);
      4:       y = DWIDTH'(3377);
      5:       y = DWIDTH'(3826);
      6:       y = DWIDTH'(4336);
      7:       y = DWIDTH'(4913);
      default: y = DWIDTH'(5567);
    endcase
    return y;
  endfunction

  logic              v1, v2;
  logic              l1, l2;
  logic              ld1, ld2, ld3;
  logic [DWIDTH-1:0] s1_lut  [LANES];
  logic              s1_clp  [LANES];
  logic [DWIDTH-1:0] s1_y0   [LANES];
  logic [DWIDTH-1:0] s1_dy   [LANES];
  logic [RB-1:0]     s1_r    [LANES];
  logic [PW-1:0]     s2_prod [LANES];
  logic              s2_clp  [LANES];
  logic [CW-1:0]     o_nsat;

  logic [DWIDTH-1:0] c1_lut  [LANES];
  logic              c1_clp  [LANES];
  logic [DWIDTH-1:0] c1_y0   [LANES];
  logic [DWIDTH-1:0] c1_dy   [LANES];
  logic [RB-1:0]     c1_r    [LANES];
  logic [PW-1:0]     c2_prod [LANES];
  logic [LANES*DWIDTH-1:0] c3_data;
  logic [CW-1:0]     c3_n;
  logic [16:0]       cnt_sum;

  assign ld3     = !o_valid || o_ready;
  assign ld2     = !v2 || ld3;
  assign ld1     = !v1 || ld2;
  assign i_ready = ld1;
  assign cnt_sum = {1'b0, o_sat_cnt} + 17'(o_nsat);

  always_comb begin
    logic [DWIDTH-1:0] x;
    logic [DWIDTH:0]   e;
    int                k;
    for (int l = 0; l < LANES; l++) begin
      x = i_data[l*DWIDTH +: DWIDTH];
      e = exp_int(int'($signed(x[DWIDTH-1 -: INT_BIT])));
      k = int'(x[FRAC_BIT-1 -: SEG_BITS]);
      c1_lut[l] = e[DWIDTH-1:0];
      c1_clp[l] = e[DWIDTH];
      c1_y0[l]  = seg_y(k);
      c1_dy[l]  = seg_y(k + 1) - seg_y(k);
      c1_r[l]   = x[RB-1:0];
    end
  end

  always_comb begin
    logic [DWIDTH+RB-1:0] t;
    logic [DWIDTH-1:0]    ef;
    for (int l = 0; l < LANES; l++) begin
      t = (DWIDTH+RB)'(s1_dy[l]) * (DWIDTH+RB)'(s1_r[l])
        + (DWIDTH+RB)'(HALF_R);
      ef = s1_y0[l] + DWIDTH'(t >> RB);
      c2_prod[l] = PW'(s1_lut[l]) * PW'(ef);
    end
  end

  always_comb begin
    logic [PW-1:0] q;
    logic          sat;
    c3_data = '0;
    c3_n    = '0;
    for (int l = 0; l < LANES; l++) begin
      q   = (s2_prod[l] + PW'(HALF_F)) >> FRAC_BIT;
      // a clamped LUT entry means e^n alone already overflows
      sat = s2_clp[l] || (q > PW'(MAXV));
      c3_data[l*DWIDTH +: DWIDTH] = sat ? MAXV : q[DWIDTH-1:0];
      c3_n = c3_n + CW'(sat);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      o_valid   <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      o_last    <= 1'b0;
      o_data    <= '0;
      o_nsat    <= '0;
      o_sat_cnt <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_lut[l]  <= '0;
        s1_clp[l]  <= 1'b0;
        s1_y0[l]   <= '0;
        s1_dy[l]   <= '0;
        s1_r[l]    <= '0;
        s2_prod[l] <= '0;
        s2_clp[l]  <= 1'b0;
      end
    end else begin
      if (o_valid && o_ready)
        o_sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      if (ld1) begin
        v1 <= i_valid;
        if (i_valid) begin
          l1     <= i_last;
          s1_lut <= c1_lut;
          s1_clp <= c1_clp;
          s1_y0  <= c1_y0;
          s1_dy  <= c1_dy;
          s1_r   <= c1_r;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          l2      <= l1;
          s2_prod <= c2_prod;
          s2_clp  <= s1_clp;
        end
      end
      if (ld3) begin
        o_valid <= v2;
        if (v2) begin
          o_last <= l2;
          o_data <= c3_data;
          o_nsat <= c3_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_exp_stream.sv
// tb_exp_stream: table vectors, stall/reset sequences and a random
// stream checked against a real-valued piecewise-linear e^x model.
module tb_exp_stream;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        i_valid, i_ready, i_last;
  logic        o_valid, o_ready, o_last;
  logic [63:0] i_data, o_data;
  logic [15:0] o_sat_cnt;

  int tests = 0;
  int fails = 0;
  int acc   = 0;

  typedef struct {
    logic [63:0] din;
    logic [63:0] dexp;
    int          tol;
    int          nsat;
  } vec_t;

  typedef struct {
    logic [63:0] din;
    logic        last;
  } sb_t;

  vec_t vec [6];
  sb_t  q [$];

  exp_stream dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_data    (i_data),
    .i_last    (i_last),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_sat_cnt (o_sat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk_b(input string nm, input logic got,
                       input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, required %b", nm, got, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  function automatic real rnd_e(input real p);
    return $floor($exp(p) * 2048.0 + 0.5);
  endfunction

  // e^n from the rounded integer table, e^f on the chord between
  // rounded endpoints of its eighth; exact in real arithmetic
  function automatic real ref_val(input logic [15:0] x);
    int  n, f, k, r;
    real y0, y1;
    n  = int'($signed(x[15:11]));
    f  = int'(x[10:0]);
    k  = f / 256;
    r  = f % 256;
    y0 = rnd_e(k / 8.0);
    y1 = rnd_e((k + 1) / 8.0);
    return rnd_e(real'(n)) * (y0 + (y1 - y0) * r / 256.0) / 2048.0;
  endfunction

  // stays clear of a narrow band around full scale where the
  // saturation decision depends on internal rounding
  function automatic logic [63:0] gen(input int mode);
    logic [63:0] d;
    logic [15:0] x;
    real         v;
    d = '0;
    for (int l = 0; l < 4; l++) begin
      if (mode == 2) begin
        x = 16'h7FFF;
      end else begin
        do begin
          x = 16'($urandom);
          if ($urandom_range(7) == 0) x[10:0] = '0;
          v = ref_val(x);
        end while (v > 32759.0 && v < 32775.0);
      end
      d[l*16 +: 16] = x;
    end
    return d;
  endfunction

  // interpolant rounding (+-0.5) is amplified by e^n <= 7.4 on top of
  // the final rounding, so non-integer lanes get 4.5 LSB against the
  // real-valued curve; integer-valued lanes must be exact
  task automatic chk_beat(input sb_t e, input logic [63:0] got,
                          input logic glast);
    int  ns, bad, g;
    real v, bv;
    ns  = 0;
    bad = -1;
    bv  = 0.0;
    for (int l = 0; l < 4; l++) begin
      v = ref_val(e.din[l*16 +: 16]);
      g = int'(got[l*16 +: 16]);
      if (v > 32767.0) begin
        ns++;
        if (g != 32767) bad = l;
      end else if (e.din[l*16 +: 11] == 11'd0) begin
        if (g != int'(v)) bad = l;
      end else if (real'(g) - v > 4.5 || v - real'(g) > 4.5) begin
        bad = l;
      end
      if (bad == l) bv = v;
    end
    tests++;
    if (bad >= 0 || glast !== e.last) begin
      fails++;
      $display("FAIL beat: in %h got %h last %b, required lane %0d ~%0.2f last %b",
               e.din, got, glast, bad, bv, e.last);
    end
    acc = (acc + ns > 65535) ? 65535 : acc + ns;
  endtask

  task automatic run_stream(input int nbeats, input int mode);
    int          sent, got, cyc, lows;
    logic        stall, pl, need;
    logic [63:0] pd, nxt;
    sb_t         e;
    sent = 0; got = 0; cyc = 0; lows = 0;
    stall = 1'b0; pl = 1'b0; need = 1'b1;
    pd = '0; nxt = '0;
    while (got < nbeats && cyc < nbeats * 8 + 50) begin
      cyc++;
      if (sent < nbeats) begin
        if (need) begin
          nxt  = gen(mode);
          need = 1'b0;
        end
        i_data  = nxt;
        i_valid = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
        i_last  = (mode == 1) ? 1'($urandom_range(1))
                              : (sent == nbeats - 1);
      end else begin
        i_valid = 1'b0;
        i_last  = 1'b0;
      end
      case (mode)
        0:       o_ready = !(cyc >= 2 && cyc <= 6);
        1:       o_ready = ($urandom_range(3) != 0);
        default: o_ready = 1'b1;
      endcase
      @(negedge clk);
      chk_b("i_ready", i_ready, !(q.size() == 3 && !o_ready));
      if (q.size() == 3 && !o_ready && i_valid) lows++;
      if (stall) begin
        chk_b("stall_valid", o_valid, 1'b1);
        chk_w("stall_data", o_data, pd);
        chk_b("stall_last", o_last, pl);
      end
      if (o_valid && o_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious: got beat %h, required none", o_data);
        end else begin
          e = q.pop_front();
          chk_beat(e, o_data, o_last);
        end
        got++;
      end
      if (i_valid && i_ready) begin
        e.din  = nxt;
        e.last = i_last;
        q.push_back(e);
        sent++;
        need = 1'b1;
      end
      stall = o_valid && !o_ready;
      pd    = o_data;
      pl    = o_last;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    o_ready = 1'b1;
    tests++;
    if (got < nbeats) begin
      fails++;
      $display("FAIL stream_timeout: got %0d beats, required %0d",
               got, nbeats);
    end
    if (mode == 0) chk_b("backpressure", lows > 0, 1'b1);
    chk_w("sat_cnt", {48'd0, o_sat_cnt}, 64'(acc));
  endtask

  initial begin
    arst_n  = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    o_ready = 1'b1;

    vec[0] = '{64'h0400_F800_0800_0000, 64'h0D30_02F1_15BF_0800, 4, 0};
    vec[1] = '{64'h1000_F800_0800_0000, 64'h3B1D_02F1_15BF_0800, 0, 0};
    vec[2] = '{64'hF000_8000_1800_7FFF, 64'h0115_0000_7FFF_7FFF, 0, 2};
    vec[3] = '{64'hC000_C800_D000_E000, 64'h0001_0002_0005_0026, 0, 0};
    vec[4] = '{64'h0600_0200_FC00_B800, 64'h10F0_0A46_04DA_0000, 0, 0};
    vec[5] = '{64'h8000_0001_17FF_1000, 64'h0000_0801_7FFF_3B1D, 0, 1};

    #12;
    chk_b("rst_o_valid", o_valid, 1'b0);
    chk_w("rst_o_data", o_data, 64'd0);
    chk_b("rst_o_last", o_last, 1'b0);
    chk_w("rst_sat_cnt", {48'd0, o_sat_cnt}, 64'd0);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_b("rst_i_ready", i_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      int g, w, bad;
      i_valid = 1'b1;
      i_data  = vec[i].din;
      i_last  = (i % 2) == 1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
      @(posedge clk);
      #1;
      chk_b("lat_early", o_valid, 1'b0);
      @(posedge clk);
      #1;
      chk_b("lat_valid", o_valid, 1'b1);
      chk_b("vec_last", o_last, (i % 2) == 1);
      bad = 0;
      for (int l = 0; l < 4; l++) begin
        g = int'(o_data[l*16 +: 16]);
        w = int'(vec[i].dexp[l*16 +: 16]);
        if (g - w > vec[i].tol || w - g > vec[i].tol) bad = 1;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL vec%0d: got %h, required %h +-%0d",
                 i, o_data, vec[i].dexp, vec[i].tol);
      end
      @(posedge clk);
      #1;
      acc += vec[i].nsat;
      chk_w("vec_sat_cnt", {48'd0, o_sat_cnt}, 64'(acc));
      chk_b("vec_drained", o_valid, 1'b0);
    end

    run_stream(10, 0);
    run_stream(12000, 1);
    run_stream((65535 - acc) / 4 + 8, 2);
    chk_w("sat_hold", {48'd0, o_sat_cnt}, 64'hFFFF);

    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_data  = {4{16'h0800}};
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    chk_b("pre_rst_valid", o_valid, 1'b1);
    chk_w("pre_rst_data", o_data, {4{16'h15BF}});
    #2;
    arst_n = 1'b0;
    #1;
    chk_b("async_o_valid", o_valid, 1'b0);
    chk_w("async_o_data", o_data, 64'd0);
    chk_b("async_o_last", o_last, 1'b0);
    chk_w("async_sat_cnt", {48'd0, o_sat_cnt}, 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    acc    = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_b("no_stale", o_valid, 1'b0);
    end
    chk_b("post_rst_ready", i_ready, 1'b1);
    i_valid = 1'b1;
    i_data  = {4{16'h1000}};
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_b("post_lat1", o_valid, 1'b0);
    @(posedge clk);
    #1;
    chk_b("post_lat2", o_valid, 1'b1);
    chk_w("post_data", o_data, {4{16'h3B1D}});
    @(posedge clk);
    #1;
    chk_w("post_sat_cnt", {48'd0, o_sat_cnt}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
